// File: rtl/mem_stage.sv
// mem_stage: pipeline memory-access stage.
// Issues one load/store per instruction over a req/ack port and emits a writeback strobe.
module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] rd_in,
  input  logic [DATA_W-1:0] rb_in,
  input  logic [7:0]        ctrl_ex,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic              wb_en,
  output logic [4:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  // The abort fires on the last permitted wait cycle, so the request
  // is visible for exactly TIMEOUT cycles when no ack ever arrives.
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_t              r_state;
  logic [7:0]          r_cnt;
  logic                r_req;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rd;
  logic [4:0]          r_reg;
  logic                r_en;
  logic                r_wb_valid;
  logic                r_wb_en;
  logic [4:0]          r_wb_reg;
  logic [DATA_W-1:0]   r_wb_data;
  logic                r_err;

  logic w_mrd;
  logic w_mwr;
  logic w_illegal;
  logic w_misal;
  logic w_accept;

  // Decode of the incoming control word and accept condition
  always_comb begin
    w_mrd     = ctrl_ex[0];
    w_mwr     = ctrl_ex[1];
    w_illegal = w_mrd & w_mwr;
    w_misal   = (w_mrd | w_mwr) & (rd_in[1:0] != 2'b00);
    w_accept  = ex_valid & (r_state == S_IDLE);
  end

  // Access FSM: accept, memory handshake, timeout abort and writeback
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd       <= '0;
      r_reg      <= '0;
      r_en       <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_en    <= 1'b0;
      r_wb_reg   <= '0;
      r_wb_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rd  <= rd_in;
            r_reg <= ctrl_ex[7:3];
            r_en  <= ctrl_ex[2];
            if (w_illegal || w_misal) begin
              r_err      <= 1'b1;
              r_wb_valid <= 1'b1;
              r_wb_en    <= 1'b0;
              r_wb_reg   <= ctrl_ex[7:3];
              r_wb_data  <= rd_in;
            end else if (w_mrd || w_mwr) begin
              r_state <= S_ACCESS;
              r_cnt   <= '0;
              r_req   <= 1'b1;
              r_we    <= w_mwr;
              r_addr  <= rd_in[ADDR_W+1:2];
              r_wdata <= rb_in;
            end else begin
              r_wb_valid <= 1'b1;
              r_wb_en    <= ctrl_ex[2];
              r_wb_reg   <= ctrl_ex[7:3];
              r_wb_data  <= rd_in;
            end
          end
        end
        S_ACCESS: begin
          if (mem_ack) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_wb_valid <= 1'b1;
            r_wb_reg   <= r_reg;
            if (r_we) begin
              r_wb_en   <= 1'b0;
              r_wb_data <= r_rd;
            end else begin
              r_wb_en   <= r_en;
              r_wb_data <= mem_rdata;
            end
          end else if (r_cnt == LP_CNT_LAST) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_err      <= 1'b1;
            r_wb_valid <= 1'b1;
            r_wb_en    <= 1'b0;
            r_wb_reg   <= r_reg;
            r_wb_data  <= r_rd;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall     = (r_state == S_ACCESS);
  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign wb_valid  = r_wb_valid;
  assign wb_en     = r_wb_en;
  assign wb_reg    = r_wb_reg;
  assign wb_data   = r_wb_data;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus with a writeback scoreboard.
// Expected packets are queued at issue time and popped by a negedge monitor.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [31:0] rd_in = '0;
  logic [31:0] rb_in = '0;
  logic [7:0]  ctrl_ex = '0;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        wb_valid;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        en;
    logic [4:0]  rg;
    logic [31:0] d;
    logic        cd;
  } exp_t;

  exp_t q[$];

  mem_stage #(.DATA_W(32), .ADDR_W(10), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ex_valid  (ex_valid),
    .rd_in     (rd_in),
    .rb_in     (rb_in),
    .ctrl_ex   (ctrl_ex),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .wb_valid  (wb_valid),
    .wb_en     (wb_en),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic push(input logic en, input logic [4:0] rg,
                      input logic [31:0] d, input logic cd);
    exp_t x;
    x.en = en;
    x.rg = rg;
    x.d  = d;
    x.cd = cd;
    q.push_back(x);
  endtask

  // Monitor: every strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got strobe reg=%0d data=%h expected none",
                 wb_reg, wb_data);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("wb_en", {31'd0, wb_en}, {31'd0, x.en});
        chk("wb_reg", {27'd0, wb_reg}, {27'd0, x.rg});
        if (x.cd) chk("wb_data", wb_data, x.d);
      end
    end
  end

  // Issue one instruction; returns at posedge+1 of the accept edge
  task automatic issue(input logic [31:0] rd, input logic [31:0] rb,
                       input logic [7:0] c);
    ex_valid = 1'b1;
    rd_in    = rd;
    rb_in    = rb;
    ctrl_ex  = c;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    chk("rst_addr", {22'd0, mem_addr}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Non-memory back-to-back, wb_en=1 reg 5
    for (int i = 0; i < 3; i++) begin
      ex_valid = 1'b1;
      rd_in    = 32'h11 * (i + 1);
      ctrl_ex  = 8'h2C;
      push(1'b1, 5'd5, 32'h11 * (i + 1), 1'b1);
      @(negedge clk);
      chk("nm_stall", {31'd0, stall}, 32'd0);
      if (i > 0) chk("nm_wbv", {31'd0, wb_valid}, 32'd1);
      @(posedge clk);
      #1;
    end
    ex_valid = 1'b0;
    @(negedge clk);
    chk("nm_wbv_last", {31'd0, wb_valid}, 32'd1);
    chk("nm_stall_last", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("nm_wbv_off", {31'd0, wb_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Load with 3 wait cycles: ack in the 4th request cycle
    push(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1);
    issue(32'h10, 32'h0, 8'h3D);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      chk("ld_stall", {31'd0, stall}, 32'd1);
      chk("ld_req", {31'd0, mem_req}, 32'd1);
      chk("ld_we", {31'd0, mem_we}, 32'd0);
      chk("ld_addr", {22'd0, mem_addr}, 32'd4);
      chk("ld_wbv", {31'd0, wb_valid}, 32'd0);
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
    end
    @(negedge clk);
    chk("ld_stall_off", {31'd0, stall}, 32'd0);
    chk("ld_req_off", {31'd0, mem_req}, 32'd0);
    chk("ld_wbv", {31'd0, wb_valid}, 32'd1);
    @(posedge clk);
    #1;

    // Zero-wait store followed by an accept two edges later
    push(1'b0, 5'd3, 32'h8, 1'b1);
    issue(32'h8, 32'hCAFE, 8'h1E);
    mem_ack = 1'b1;
    @(negedge clk);
    chk("st_req", {31'd0, mem_req}, 32'd1);
    chk("st_we", {31'd0, mem_we}, 32'd1);
    chk("st_wdata", mem_wdata, 32'hCAFE);
    chk("st_addr", {22'd0, mem_addr}, 32'd2);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    push(1'b1, 5'd5, 32'h44, 1'b1);
    ex_valid = 1'b1;
    rd_in    = 32'h44;
    ctrl_ex  = 8'h2C;
    @(negedge clk);
    chk("st_stall_off", {31'd0, stall}, 32'd0);
    chk("st_wbv", {31'd0, wb_valid}, 32'd1);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    @(negedge clk);
    chk("st_next_wbv", {31'd0, wb_valid}, 32'd1);
    chk("st_next_data", wb_data, 32'h44);
    @(posedge clk);
    #1;

    // Timeout with TIMEOUT=4, then a late ack
    push(1'b0, 5'd9, 32'h0, 1'b0);
    issue(32'h20, 32'h0, 8'h4D);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_req", {31'd0, mem_req}, 32'd1);
      chk("to_err", {31'd0, err}, 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("to_req_off", {31'd0, mem_req}, 32'd0);
    chk("to_err_set", {31'd0, err}, 32'd1);
    chk("to_wbv", {31'd0, wb_valid}, 32'd1);
    @(posedge clk);
    #1;
    mem_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("late_ack_wbv", {31'd0, wb_valid}, 32'd0);
      chk("late_ack_req", {31'd0, mem_req}, 32'd0);
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;
    pulse_rst();
    @(negedge clk);
    chk("rst_clr_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1;

    // Misaligned load
    push(1'b0, 5'd4, 32'h0, 1'b0);
    issue(32'h6, 32'h0, 8'h25);
    @(negedge clk);
    chk("mis_req", {31'd0, mem_req}, 32'd0);
    chk("mis_stall", {31'd0, stall}, 32'd0);
    chk("mis_err", {31'd0, err}, 32'd1);
    chk("mis_wbv", {31'd0, wb_valid}, 32'd1);
    @(posedge clk);
    #1;
    pulse_rst();

    // Both mem_rd and mem_wr set
    push(1'b0, 5'd4, 32'h0, 1'b0);
    issue(32'h10, 32'h0, 8'h27);
    @(negedge clk);
    chk("ill_req", {31'd0, mem_req}, 32'd0);
    chk("ill_stall", {31'd0, stall}, 32'd0);
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_wbv", {31'd0, wb_valid}, 32'd1);
    @(posedge clk);
    #1;

    // Reset during ACCESS (err still set from the illegal case)
    issue(32'h10, 32'h0, 8'h3D);
    @(negedge clk);
    chk("ra_req", {31'd0, mem_req}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("ra_req_async", {31'd0, mem_req}, 32'd0);
    chk("ra_stall_async", {31'd0, stall}, 32'd0);
    chk("ra_err_async", {31'd0, err}, 32'd0);
    chk("ra_wbv_async", {31'd0, wb_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    chk("ra_ack_wbv", {31'd0, wb_valid}, 32'd0);
    chk("ra_ack_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ra_ack_wbv2", {31'd0, wb_valid}, 32'd0);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    push(1'b1, 5'd7, 32'h1234_5678, 1'b1);
    issue(32'h14, 32'h0, 8'h3D);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("ra_new_addr", {22'd0, mem_addr}, 32'd5);
    chk("ra_new_req", {31'd0, mem_req}, 32'd1);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("ra_new_wbv", {31'd0, wb_valid}, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
